// File: rtl/fpu_ss_writeback.sv
// Writeback stage of the FPU subsystem: routes FPU results and load data to the
// FP register file, and integer results / load errors to the core via a small FIFO.
module fpu_ss_writeback #(
    parameter int RESULT_DEPTH = 2,
    parameter int X_ID_WIDTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    fpu_out_valid_i,
    output logic                    fpu_out_ready_o,
    input  logic [31:0]             fpu_result_i,
    input  logic [9:0]              fpu_tag_i,
    input  logic [4:0]              fpu_status_i,
    input  logic                    mem_result_valid_i,
    input  logic [31:0]             mem_rdata_i,
    input  logic [4:0]              mem_rd_i,
    input  logic [3:0]              mem_id_i,
    input  logic                    mem_err_i,
    output logic                    fpr_we_o,
    output logic [4:0]              fpr_waddr_o,
    output logic [31:0]             fpr_wdata_o,
    output logic                    fflags_we_o,
    output logic [4:0]              fflags_o,
    output logic                    x_result_valid_o,
    input  logic                    x_result_ready_i,
    output logic [X_ID_WIDTH+45:0]  x_result_o,
    output logic                    overflow_o
);

    // x_result_o packs {id, data, rd, we, float, exc, exccode}, MSB first.
    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
        logic                  is_float;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    localparam int PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESULT_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(RESULT_DEPTH);
    localparam logic [CNT_W-1:0] INT_LIMIT    = CNT_W'(RESULT_DEPTH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR     = PTR_W'(RESULT_DEPTH - 1);
    localparam logic [5:0]       LOAD_FAULT   = 6'd5;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    x_result_t              entries [RESULT_DEPTH];
    logic [PTR_W-1:0]       rptr_q, wptr_q, wptr_second, wptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [4:0]             tag_addr;
    logic                   tag_is_fp;
    logic [3:0]             tag_id;
    logic                   fpu_fire, fp_fire, fpu_push;
    logic                   load_ok, err_req, err_push, err_drop, pop;
    x_result_t              err_entry, int_entry;

    assign tag_addr  = fpu_tag_i[9:5];
    assign tag_is_fp = fpu_tag_i[4];
    assign tag_id    = fpu_tag_i[3:0];

    // Valid/ready: a transfer happens on any cycle where valid & ready are both high.
    // FP results yield the regfile port to loads; integer results leave one FIFO
    // slot free so a load error can always be queued.
    assign fpu_out_ready_o = tag_is_fp ? !mem_result_valid_i : (count_q < INT_LIMIT);
    assign fpu_fire        = fpu_out_valid_i && fpu_out_ready_o;
    assign fp_fire         = fpu_fire && tag_is_fp;
    assign fpu_push        = fpu_fire && !tag_is_fp;

    assign pop      = (count_q != '0) && x_result_ready_i;
    assign load_ok  = mem_result_valid_i && !mem_err_i;
    assign err_req  = mem_result_valid_i && mem_err_i;
    assign err_push = err_req && ((count_q < DEPTH_CNT) || pop);
    assign err_drop = err_req && !err_push;

    always_comb begin
        err_entry          = '0;
        err_entry.id       = X_ID_WIDTH'(mem_id_i);
        err_entry.rd       = mem_rd_i;
        err_entry.is_float = 1'b1;
        err_entry.exc      = 1'b1;
        err_entry.exccode  = LOAD_FAULT;

        int_entry          = '0;
        int_entry.id       = X_ID_WIDTH'(tag_id);
        int_entry.data     = fpu_result_i;
        int_entry.rd       = tag_addr;
        int_entry.we       = 1'b1;
    end

    // The load error takes the earlier slot when both pushes land together.
    assign wptr_second = err_push ? ptr_next(wptr_q) : wptr_q;
    assign wptr_d      = fpu_push ? ptr_next(wptr_second) : wptr_second;
    assign count_d     = count_q + CNT_W'(err_push) + CNT_W'(fpu_push) - CNT_W'(pop);

    always_ff @(posedge clk_i) begin
        if (err_push) entries[wptr_q]      <= err_entry;
        if (fpu_push) entries[wptr_second] <= int_entry;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
            if (pop) rptr_q <= ptr_next(rptr_q);
        end
    end

    // Empty FIFO presents zeros so stale storage never leaks out.
    assign x_result_valid_o = (count_q != '0);
    assign x_result_o       = x_result_valid_o ? entries[rptr_q] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fpr_we_o    <= 1'b0;
            fpr_waddr_o <= '0;
            fpr_wdata_o <= '0;
            fflags_we_o <= 1'b0;
            fflags_o    <= '0;
            overflow_o  <= 1'b0;
        end else begin
            fpr_we_o    <= load_ok || fp_fire;
            fflags_we_o <= fpu_fire;
            if (load_ok) begin
                fpr_waddr_o <= mem_rd_i;
                fpr_wdata_o <= mem_rdata_i;
            end else if (fp_fire) begin
                fpr_waddr_o <= tag_addr;
                fpr_wdata_o <= fpu_result_i;
            end
            if (fpu_fire) fflags_o <= fpu_status_i;
            if (err_drop) overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_ss_writeback.sv
// Self-checking bench for fpu_ss_writeback: per-feature tasks plus a scoreboard
// queue for the x_result channel and one-cycle-ahead expectations for the regfile.
module tb_fpu_ss_writeback;

    localparam int DEPTH = 2;
    localparam int IDW   = 4;
    localparam int XW    = IDW + 46;

    logic          clk, rst_n;
    logic          fpu_out_valid_i, fpu_out_ready_o;
    logic [31:0]   fpu_result_i;
    logic [9:0]    fpu_tag_i;
    logic [4:0]    fpu_status_i;
    logic          mem_result_valid_i;
    logic [31:0]   mem_rdata_i;
    logic [4:0]    mem_rd_i;
    logic [3:0]    mem_id_i;
    logic          mem_err_i;
    logic          fpr_we_o;
    logic [4:0]    fpr_waddr_o;
    logic [31:0]   fpr_wdata_o;
    logic          fflags_we_o;
    logic [4:0]    fflags_o;
    logic          x_result_valid_o, x_result_ready_i;
    logic [XW-1:0] x_result_o;
    logic          overflow_o;

    int total = 0;
    int bad   = 0;

    logic [XW-1:0] exp_q[$];
    logic          exp_fpr_we, exp_ff_we, exp_ovf, last_acc;
    logic [4:0]    exp_waddr, exp_ff;
    logic [31:0]   exp_wdata;

    fpu_ss_writeback #(.RESULT_DEPTH(DEPTH), .X_ID_WIDTH(IDW)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .fpu_out_valid_i    (fpu_out_valid_i),
        .fpu_out_ready_o    (fpu_out_ready_o),
        .fpu_result_i       (fpu_result_i),
        .fpu_tag_i          (fpu_tag_i),
        .fpu_status_i       (fpu_status_i),
        .mem_result_valid_i (mem_result_valid_i),
        .mem_rdata_i        (mem_rdata_i),
        .mem_rd_i           (mem_rd_i),
        .mem_id_i           (mem_id_i),
        .mem_err_i          (mem_err_i),
        .fpr_we_o           (fpr_we_o),
        .fpr_waddr_o        (fpr_waddr_o),
        .fpr_wdata_o        (fpr_wdata_o),
        .fflags_we_o        (fflags_we_o),
        .fflags_o           (fflags_o),
        .x_result_valid_o   (x_result_valid_o),
        .x_result_ready_i   (x_result_ready_i),
        .x_result_o         (x_result_o),
        .overflow_o         (overflow_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [XW-1:0] res(input logic [3:0] id, input logic [31:0] data,
                                          input logic [4:0] rd, input logic we, input logic fl,
                                          input logic exc, input logic [5:0] code);
        return {id, data, rd, we, fl, exc, code};
    endfunction

    // driver tasks
    task automatic idle_inputs();
        fpu_out_valid_i    = 1'b0;
        mem_result_valid_i = 1'b0;
        mem_err_i          = 1'b0;
    endtask

    task automatic set_fpu(input logic [4:0] addr, input logic is_fp, input logic [3:0] id,
                           input logic [31:0] data, input logic [4:0] st);
        fpu_out_valid_i = 1'b1;
        fpu_tag_i       = {addr, is_fp, id};
        fpu_result_i    = data;
        fpu_status_i    = st;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [3:0] id,
                            input logic [31:0] data, input logic err);
        mem_result_valid_i = 1'b1;
        mem_rd_i           = rd;
        mem_id_i           = id;
        mem_rdata_i        = data;
        mem_err_i          = err;
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_fpr_we = 1'b0;
        exp_ff_we  = 1'b0;
        exp_ovf    = 1'b0;
        exp_waddr  = '0;
        exp_wdata  = '0;
        exp_ff     = '0;
        last_acc   = 1'b0;
    endtask

    // One cycle: check outputs at the falling edge, account for what the rising
    // edge will accept, then return just after that rising edge.
    task automatic tick();
        int   sz;
        logic popping, is_fp, exp_rdy, acc;
        @(negedge clk);
        total++;
        if (fpr_we_o !== exp_fpr_we) begin
            bad++; $display("FAIL fpr_we: got %b expected %b", fpr_we_o, exp_fpr_we);
        end
        if (exp_fpr_we) begin
            total++;
            if ({fpr_waddr_o, fpr_wdata_o} !== {exp_waddr, exp_wdata}) begin
                bad++; $display("FAIL fpr_write: got %0d/%h expected %0d/%h",
                                fpr_waddr_o, fpr_wdata_o, exp_waddr, exp_wdata);
            end
        end
        total++;
        if (fflags_we_o !== exp_ff_we) begin
            bad++; $display("FAIL fflags_we: got %b expected %b", fflags_we_o, exp_ff_we);
        end
        if (exp_ff_we) begin
            total++;
            if (fflags_o !== exp_ff) begin
                bad++; $display("FAIL fflags: got %b expected %b", fflags_o, exp_ff);
            end
        end
        total++;
        if (overflow_o !== exp_ovf) begin
            bad++; $display("FAIL overflow: got %b expected %b", overflow_o, exp_ovf);
        end
        sz = exp_q.size();
        total++;
        if (x_result_valid_o !== (sz != 0)) begin
            bad++; $display("FAIL x_valid: got %b expected %b", x_result_valid_o, sz != 0);
        end
        if (sz != 0) begin
            total++;
            if (x_result_o !== exp_q[0]) begin
                bad++; $display("FAIL x_result: got %h expected %h", x_result_o, exp_q[0]);
            end
        end
        popping = (sz != 0) && x_result_ready_i;
        is_fp   = fpu_tag_i[4];
        exp_rdy = is_fp ? !mem_result_valid_i : (sz < DEPTH - 1);
        total++;
        if (fpu_out_ready_o !== exp_rdy) begin
            bad++; $display("FAIL fpu_ready: got %b expected %b", fpu_out_ready_o, exp_rdy);
        end
        acc        = fpu_out_valid_i && exp_rdy;
        last_acc   = acc;
        exp_fpr_we = 1'b0;
        exp_ff_we  = acc;
        if (acc) exp_ff = fpu_status_i;
        if (mem_result_valid_i && !mem_err_i) begin
            exp_fpr_we = 1'b1; exp_waddr = mem_rd_i; exp_wdata = mem_rdata_i;
        end else if (acc && is_fp) begin
            exp_fpr_we = 1'b1; exp_waddr = fpu_tag_i[9:5]; exp_wdata = fpu_result_i;
        end
        if (popping) void'(exp_q.pop_front());
        if (mem_result_valid_i && mem_err_i) begin
            if (sz < DEPTH || popping)
                exp_q.push_back(res(mem_id_i, 32'h0, mem_rd_i, 1'b0, 1'b1, 1'b1, 6'd5));
            else
                exp_ovf = 1'b1;
        end
        if (acc && !is_fp)
            exp_q.push_back(res(fpu_tag_i[3:0], fpu_result_i, fpu_tag_i[9:5], 1'b1, 1'b0, 1'b0, 6'd0));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        fpu_tag_i = {5'd0, 1'b1, 4'd0};
        fpu_result_i = '0; fpu_status_i = '0;
        mem_rdata_i = '0; mem_rd_i = '0; mem_id_i = '0;
        x_result_ready_i = 1'b0;
        reset_model();
        #2;
        total++;
        if ({fpr_we_o, fpr_waddr_o, fpr_wdata_o, fflags_we_o, fflags_o, x_result_valid_o,
             x_result_o, overflow_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %b/%0d/%h/%b/%b/%b/%h/%b expected all zero",
                            fpr_we_o, fpr_waddr_o, fpr_wdata_o, fflags_we_o, fflags_o,
                            x_result_valid_o, x_result_o, overflow_o);
        end
        total++;
        if (fpu_out_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready_idle: got %b expected 1", fpu_out_ready_o);
        end
        mem_result_valid_i = 1'b1;
        #1;
        total++;
        if (fpu_out_ready_o !== 1'b0) begin
            bad++; $display("FAIL reset_ready_mem: got %b expected 0", fpu_out_ready_o);
        end
        mem_result_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fp_result();
        set_fpu(5'd7, 1'b1, 4'd3, 32'h3F800000, 5'b00001);
        tick();
        idle_inputs();
        total++;
        if ({fpr_we_o, fpr_waddr_o, fpr_wdata_o, fflags_o} !== {1'b1, 5'd7, 32'h3F800000, 5'b00001}) begin
            bad++; $display("FAIL fp_result: got %b/%0d/%h/%b expected 1/7/3f800000/00001",
                            fpr_we_o, fpr_waddr_o, fpr_wdata_o, fflags_o);
        end
        tick();
        tick();
    endtask

    task automatic test_port_conflict();
        set_load(5'd4, 4'd0, 32'hDEADBEEF, 1'b0);
        set_fpu(5'd5, 1'b1, 4'd2, 32'h40490FDB, 5'b00010);
        tick();
        mem_result_valid_i = 1'b0;
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        x_result_ready_i = 1'b0;
        set_fpu(5'd10, 1'b0, 4'd1, 32'h11111111, 5'b00000);
        tick();
        set_fpu(5'd11, 1'b0, 4'd2, 32'h22222222, 5'b00100);
        tick();
        total++;
        if (fpu_out_ready_o !== 1'b0) begin
            bad++; $display("FAIL backpressure_ready: got %b expected 0", fpu_out_ready_o);
        end
        tick();
        x_result_ready_i = 1'b1;
        tick();
        tick();
        idle_inputs();
        tick();
        tick();
        total++;
        if (x_result_valid_o !== 1'b0) begin
            bad++; $display("FAIL backpressure_drain: got %b expected 0", x_result_valid_o);
        end
    endtask

    task automatic test_load_error();
        x_result_ready_i = 1'b0;
        set_fpu(5'd2, 1'b0, 4'd1, 32'hA5A5A5A5, 5'b00000);
        tick();
        idle_inputs();
        set_load(5'd3, 4'd9, 32'h12345678, 1'b1);
        tick();
        set_load(5'd6, 4'd10, 32'h0, 1'b1);
        tick();
        idle_inputs();
        total++;
        if (overflow_o !== 1'b1) begin
            bad++; $display("FAIL overflow_set: got %b expected 1", overflow_o);
        end
        tick();
        x_result_ready_i = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (overflow_o !== 1'b1) begin
            bad++; $display("FAIL overflow_sticky: got %b expected 1", overflow_o);
        end
    endtask

    task automatic test_push_pop_wrap();
        x_result_ready_i = 1'b0;
        set_fpu(5'd1, 1'b0, 4'd4, 32'hCAFEF00D, 5'b10000);
        tick();
        idle_inputs();
        set_load(5'd2, 4'd5, 32'h0, 1'b1);
        tick();
        x_result_ready_i = 1'b1;
        set_load(5'd7, 4'd6, 32'h0, 1'b1);
        tick();
        set_load(5'd8, 4'd7, 32'h0, 1'b1);
        tick();
        idle_inputs();
        repeat (3) tick();
        x_result_ready_i = 1'b0;
        set_fpu(5'd9, 1'b0, 4'd8, 32'h87654321, 5'b01000);
        set_load(5'd12, 4'd11, 32'h0, 1'b1);
        tick();
        idle_inputs();
        x_result_ready_i = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            x_result_ready_i   = ($urandom_range(0, 3) != 0);
            mem_result_valid_i = ($urandom_range(0, 3) == 0);
            mem_err_i          = ($urandom_range(0, 2) == 0);
            mem_rd_i           = 5'($urandom_range(0, 31));
            mem_id_i           = 4'($urandom_range(0, 15));
            mem_rdata_i        = $urandom;
            if (!fpu_out_valid_i || last_acc) begin
                fpu_out_valid_i = ($urandom_range(0, 1) == 1);
                fpu_tag_i       = 10'($urandom_range(0, 1023));
                fpu_result_i    = $urandom;
                fpu_status_i    = 5'($urandom_range(0, 31));
            end
            tick();
        end
        idle_inputs();
        x_result_ready_i = 1'b1;
        repeat (4) tick();
        total++;
        if (x_result_valid_o !== 1'b0) begin
            bad++; $display("FAIL random_drain: got %b expected 0", x_result_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        x_result_ready_i = 1'b0;
        fpu_tag_i = {5'd0, 1'b0, 4'd0};
        set_fpu(5'd14, 1'b0, 4'd1, 32'h0F0F0F0F, 5'b00011);
        tick();
        idle_inputs();
        set_load(5'd15, 4'd2, 32'h0, 1'b1);
        tick();
        set_load(5'd13, 4'd3, 32'h000055AA, 1'b0);
        tick();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        total++;
        if ({fpr_we_o, fpr_waddr_o, fpr_wdata_o, fflags_we_o, fflags_o, x_result_valid_o,
             x_result_o, overflow_o} !== '0) begin
            bad++; $display("FAIL reset_mid_outputs: got %b/%0d/%h/%b/%b/%b/%h/%b expected all zero",
                            fpr_we_o, fpr_waddr_o, fpr_wdata_o, fflags_we_o, fflags_o,
                            x_result_valid_o, x_result_o, overflow_o);
        end
        reset_model();
        #2;
        rst_n = 1'b1;
        x_result_ready_i = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_fp_result();
        test_port_conflict();
        test_backpressure();
        test_load_error();
        test_push_pop_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
